vmem_sequencer: RTL and testbench

- Sits between the MEM stage of the 5-stage pipeline and the single-port data RAM.
- Scalar (32-bit) accesses pass straight through with no added latency.
- Vector (48-bit) loads and stores are split into one RAM access per lane. The block stalls the pipeline while the lanes are sequenced, then returns the assembled vector or a store acknowledge.

---
 rtl/vmem_sequencer.sv | 131 +++++++++++++
 tb/tb_vmem_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmem_sequencer.sv
// Memory-stage sequencer: scalar accesses pass straight to the single-port RAM,
// vector accesses are split into one RAM word per lane while the pipeline is stalled.
module vmem_sequencer #(
  parameter int LANES  = 6,
  parameter int LANE_W = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic                     req_vec,
  input  logic                     req_write,
  input  logic [DATA_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  input  logic [LANES*LANE_W-1:0]  req_wdata_v,
  output logic                     stall,
  output logic                     resp_valid,
  output logic [DATA_W-1:0]        resp_rdata,
  output logic [LANES*LANE_W-1:0]  resp_rdata_v,
  output logic [ADDR_W-1:0]        ram_address,
  output logic [DATA_W-1:0]        ram_data,
  output logic                     ram_wren,
  input  logic [DATA_W-1:0]        ram_q
);

  localparam int VEC_W   = LANES * LANE_W;
  localparam int LANE_CW = $clog2(LANES + 1);

  typedef enum logic [1:0] {IDLE, VWR, VRD, DONE} state_t;

  state_t              state_q;
  logic [LANE_CW-1:0]  lane_q;
  logic [ADDR_W-1:0]   base_addr_q;
  logic [VEC_W-1:0]    wdata_v_q;
  logic [VEC_W-1:0]    asm_q;
  logic [VEC_W-1:0]    rdata_v_q;
  logic                is_write_q;

  logic                vec_start;
  logic [ADDR_W-1:0]   lane_addr;
  logic [LANE_W-1:0]   wr_slice;

  assign vec_start    = (state_q == IDLE) && req_valid && req_vec;
  assign lane_addr    = base_addr_q + ADDR_W'(lane_q);
  assign resp_rdata   = ram_q;
  assign resp_rdata_v = rdata_v_q;

  always_comb begin
    wr_slice = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_q == LANE_CW'(i)) wr_slice = wdata_v_q[i*LANE_W +: LANE_W];
    end
  end

  // IDLE is a transparent path to the RAM; the other states drive it from latched state.
  always_comb begin
    stall       = 1'b0;
    resp_valid  = 1'b0;
    ram_wren    = 1'b0;
    ram_address = req_addr[ADDR_W-1:0];
    ram_data    = req_wdata;
    case (state_q)
      IDLE: begin
        stall    = vec_start;
        ram_wren = req_valid & ~req_vec & req_write;
      end
      VWR: begin
        stall       = 1'b1;
        ram_wren    = is_write_q;
        ram_address = lane_addr;
        ram_data    = DATA_W'(wr_slice);
      end
      VRD: begin
        stall       = 1'b1;
        ram_address = lane_addr;
      end
      DONE: resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lane_q      <= '0;
      base_addr_q <= '0;
      wdata_v_q   <= '0;
      is_write_q  <= 1'b0;
      asm_q       <= '0;
      rdata_v_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (vec_start) begin
            base_addr_q <= req_addr[ADDR_W-1:0];
            wdata_v_q   <= req_wdata_v;
            is_write_q  <= req_write;
            lane_q      <= '0;
            asm_q       <= '0;
            state_q     <= req_write ? VWR : VRD;
          end
        end
        VWR: begin
          lane_q <= lane_q + 1'b1;
          if (lane_q == LANE_CW'(LANES - 1)) state_q <= DONE;
        end
        VRD: begin
          // RAM data lags its address by one cycle, so lane n-1 lands while lane_q is n.
          for (int i = 0; i < LANES; i++) begin
            if (lane_q == LANE_CW'(i + 1)) asm_q[i*LANE_W +: LANE_W] <= ram_q[LANE_W-1:0];
          end
          if (lane_q == LANE_CW'(LANES)) begin
            rdata_v_q <= {ram_q[LANE_W-1:0], asm_q[VEC_W-LANE_W-1:0]};
            state_q   <= DONE;
          end else begin
            lane_q <= lane_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  if (ADDR_W < DATA_W) begin : g_unused
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[DATA_W-1:ADDR_W];
  end

endmodule

// File: tb/tb_vmem_sequencer.sv
// Bench for vmem_sequencer: behavioural RAM, word-array reference model, fixed
// vector table, hand-written reset/back-to-back sequences and random traffic.
module tb_vmem_sequencer;

  localparam int LANES  = 6;
  localparam int LANE_W = 8;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int VEC_W  = LANES * LANE_W;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_vec, req_write;
  logic [DATA_W-1:0] req_addr, req_wdata;
  logic [VEC_W-1:0]  req_wdata_v;
  logic              stall, resp_valid, ram_wren;
  logic [DATA_W-1:0] resp_rdata, ram_data;
  logic [VEC_W-1:0]  resp_rdata_v;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_q = '0;

  logic [DATA_W-1:0] ram_mem [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] ref_mem [DEPTH] = '{default: '0};
  logic [VEC_W-1:0]  exp_q[$];
  logic [VEC_W-1:0]  last_rv = '0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic              vec;
    logic              wr;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [VEC_W-1:0]  wdata_v;
    int                exp_stall;
    int                exp_wren;
    logic [VEC_W-1:0]  exp_rd;
  } vec_t;

  vec_t tbl [12];

  vmem_sequencer #(.LANES(LANES), .LANE_W(LANE_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_vec(req_vec), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wdata_v(req_wdata_v),
    .stall(stall), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_rdata_v(resp_rdata_v),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  // Clock and external single-port RAM with registered read data.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_address] <= ram_data;
    ram_q <= ram_mem[ram_address];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: RAM as a plain word array, lanes at (base + i) mod DEPTH.
  task automatic model_apply(input logic vec, input logic wr, input logic [DATA_W-1:0] addr,
                             input logic [DATA_W-1:0] wdata, input logic [VEC_W-1:0] wdata_v,
                             output logic [VEC_W-1:0] rd);
    int a;
    int ai;
    a  = int'(addr[ADDR_W-1:0]);
    rd = '0;
    if (!vec) begin
      if (wr) ref_mem[a] = wdata;
      else    rd = VEC_W'(ref_mem[a]);
    end else begin
      for (int i = 0; i < LANES; i++) begin
        ai = (a + i) % DEPTH;
        if (wr) ref_mem[ai] = DATA_W'(wdata_v[i*LANE_W +: LANE_W]);
        else    rd[i*LANE_W +: LANE_W] = ref_mem[ai][LANE_W-1:0];
      end
    end
  endtask

  function automatic int rule_stall(input logic vec, input logic wr);
    return vec ? (wr ? LANES + 1 : LANES + 2) : 0;
  endfunction

  function automatic int rule_wren(input logic vec, input logic wr);
    return vec ? (wr ? LANES : 0) : (wr ? 1 : 0);
  endfunction

  task automatic pop_check(input string name, input logic [VEC_W-1:0] act, output logic [VEC_W-1:0] e);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      e = '0;
      $display("FAIL %s: got 0x%0h, expected nothing (scoreboard empty)", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, act, e);
    end
  endtask

  task automatic issue(input logic vec, input logic wr, input logic [DATA_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata, input logic [VEC_W-1:0] wdata_v);
    @(negedge clk);
    req_valid   = 1'b1;
    req_vec     = vec;
    req_write   = wr;
    req_addr    = addr;
    req_wdata   = wdata;
    req_wdata_v = wdata_v;
    #1;
  endtask

  // Follows one request from its first cycle to the cycle stall drops, request held throughout.
  task automatic wait_done(input string name, input logic vec, input int exp_st, input int exp_wr,
                           output logic [VEC_W-1:0] rv);
    int st, wrn, rs;
    bit done;
    st = 0; wrn = 0; rs = 0; done = 1'b0; rv = '0;
    for (int c = 0; c < 64 && !done; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      if (ram_wren) wrn++;
      if (resp_valid) begin
        rs++;
        rv = resp_rdata_v;
      end
      if (stall) st++;
      else begin
        done = 1'b1;
        check({name, " resp at stall drop"}, resp_valid, vec);
      end
    end
    check({name, " completed"}, done, 1);
    check({name, " stall cycles"}, st, exp_st);
    check({name, " wren cycles"}, wrn, exp_wr);
    check({name, " resp pulses"}, rs, vec ? 1 : 0);
  endtask

  task automatic idle_cycle(input string name);
    @(negedge clk);
    req_valid   = 1'b0;
    req_vec     = 1'($urandom_range(0, 1));
    req_write   = 1'($urandom_range(0, 1));
    req_addr    = $urandom;
    req_wdata   = $urandom;
    req_wdata_v = VEC_W'({$urandom, $urandom});
    #1;
    check({name, " idle stall"}, stall, 0);
    check({name, " idle resp_valid"}, resp_valid, 0);
    check({name, " idle wren"}, ram_wren, 0);
  endtask

  task automatic do_op(input string name, input logic vec, input logic wr, input logic [DATA_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata, input logic [VEC_W-1:0] wdata_v,
                       input int exp_st, input int exp_wr);
    logic [VEC_W-1:0] rv, e;
    issue(vec, wr, addr, wdata, wdata_v);
    wait_done(name, vec, exp_st, exp_wr, rv);
    if (vec && !wr) begin
      pop_check({name, " vec rdata"}, rv, e);
      last_rv = e;
    end
    idle_cycle(name);
    if (!vec && !wr) pop_check({name, " scalar rdata"}, VEC_W'(resp_rdata), e);
    check({name, " rdata_v hold"}, resp_rdata_v, last_rv);
  endtask

  task automatic model_op(input string name, input logic vec, input logic wr, input logic [DATA_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input logic [VEC_W-1:0] wdata_v);
    logic [VEC_W-1:0] rd;
    model_apply(vec, wr, addr, wdata, wdata_v, rd);
    if (!wr) exp_q.push_back(rd);
    do_op(name, vec, wr, addr, wdata, wdata_v, rule_stall(vec, wr), rule_wren(vec, wr));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [VEC_W-1:0] rv, e, dummy;

    tbl[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 48'h0,              0,         1,     48'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         48'h0,              0,         0,     48'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h0,         48'h0605_0403_0201, LANES + 1, LANES, 48'h0};
    tbl[3]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         48'h0,              LANES + 2, 0,     48'h0605_0403_0201};
    tbl[4]  = '{1'b1, 1'b1, 32'h0000_00FE, 32'h0,         48'hAABB_CCDD_EEFF, LANES + 1, LANES, 48'h0};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_00FE, 32'h0,         48'h0,              LANES + 2, 0,     48'hAABB_CCDD_EEFF};
    tbl[6]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         48'h0,              0,         0,     48'hDD};
    tbl[7]  = '{1'b0, 1'b0, 32'h0000_0003, 32'h0,         48'h0,              0,         0,     48'hAA};
    tbl[8]  = '{1'b0, 1'b0, 32'h0000_00FF, 32'h0,         48'h0,              0,         0,     48'hEE};
    tbl[9]  = '{1'b0, 1'b1, 32'h0000_0030, 32'hFFFF_FF80, 48'h0,              0,         1,     48'h0};
    tbl[10] = '{1'b1, 1'b0, 32'h0000_002E, 32'h0,         48'h0,              LANES + 2, 0,     48'h0000_0080_0000};
    tbl[11] = '{1'b0, 1'b0, 32'hABCD_0021, 32'h0,         48'h0,              0,         0,     48'h02};

    rst = 1'b1;
    req_valid = 1'b0; req_vec = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_wdata_v = '0;
    @(negedge clk);
    #1;
    check("reset stall", stall, 0);
    check("reset resp_valid", resp_valid, 0);
    check("reset wren", ram_wren, 0);
    check("reset rdata_v", resp_rdata_v, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 12; k++) begin
      model_apply(tbl[k].vec, tbl[k].wr, tbl[k].addr, tbl[k].wdata, tbl[k].wdata_v, dummy);
      if (!tbl[k].wr) exp_q.push_back(tbl[k].exp_rd);
      do_op($sformatf("tbl%0d", k), tbl[k].vec, tbl[k].wr, tbl[k].addr, tbl[k].wdata,
            tbl[k].wdata_v, tbl[k].exp_stall, tbl[k].exp_wren);
    end

    // Vector load held through DONE, then a scalar load issued on the very next cycle.
    model_apply(1'b1, 1'b0, 32'h20, '0, '0, e);
    exp_q.push_back(e);
    issue(1'b1, 1'b0, 32'h20, '0, '0);
    wait_done("b2b vec", 1'b1, LANES + 2, 0, rv);
    pop_check("b2b vec rdata", rv, e);
    last_rv = e;
    model_apply(1'b0, 1'b0, 32'h10, '0, '0, e);
    exp_q.push_back(e);
    issue(1'b0, 1'b0, 32'h10, '0, '0);
    check("b2b scalar stall", stall, 0);
    check("b2b scalar addr", ram_address, 8'h10);
    check("b2b scalar wren", ram_wren, 0);
    check("b2b scalar resp_valid", resp_valid, 0);
    idle_cycle("b2b");
    pop_check("b2b scalar rdata", VEC_W'(resp_rdata), e);
    check("b2b rdata_v hold", resp_rdata_v, last_rv);

    // Reset while lane 3 of a vector store is being driven.
    for (int a = 3; a < 6; a++) model_op($sformatf("prefill%0d", a), 1'b0, 1'b1, 32'h40 + a, 32'h1234_5678, '0);
    issue(1'b1, 1'b1, 32'h40, '0, 48'h6655_4433_2211);
    repeat (4) @(negedge clk);
    #1;
    check("midrst stall before", stall, 1);
    check("midrst wren before", ram_wren, 1);
    check("midrst addr before", ram_address, 8'h43);
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    check("midrst stall", stall, 0);
    check("midrst wren", ram_wren, 0);
    check("midrst resp_valid", resp_valid, 0);
    check("midrst rdata_v", resp_rdata_v, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) ref_mem[8'h40 + i] = DATA_W'((i + 1) * 8'h11);
    last_rv = '0;
    model_op("post rst ld 42", 1'b0, 1'b0, 32'h42, '0, '0);
    model_op("post rst ld 43", 1'b0, 1'b0, 32'h43, '0, '0);

    for (int n = 0; n < 40; n++) begin
      model_op($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom, $urandom, VEC_W'({$urandom, $urandom}));
    end

    for (int a = 0; a < DEPTH; a++) check($sformatf("mem[%0h]", a), ram_mem[a], ref_mem[a]);
    check("scoreboard drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
